// File: rtl/plot_sink_pkg.sv
// Shared screen geometry, framebuffer widths, FSM encoding and queue entry type
// for the plot sink and its pixel FIFO.
package plot_sink_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 3;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    // Address of the bottom-right pixel; the clear sweep ends here.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    // Row-major framebuffer address; y*160 + x always fits in 15 bits for
    // in-range coordinates.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                      input logic [Y_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO of queued pixel writes ({addr, colour} entries) with
// full/empty flags and an occupancy count.
module plot_fifo
    import plot_sink_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rset,
    input  logic                     push,
    input  pixel_t                   wr_data,
    input  logic                     pop,
    output pixel_t                   rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pixel_t             storage [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = storage[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage write port.
    // NOTE: the storage array has no reset; an entry is only read after it has
    // been written, and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/plot_sink.sv
// Pixel-write sink: range-checks incoming plots, queues them, and drives a
// framebuffer write port one acknowledged word at a time; also performs a
// full-screen clear once queued pixels have drained.
module plot_sink
    import plot_sink_pkg::*;
#(
    parameter int                  FIFO_DEPTH   = 4,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = 3'b000
) (
    input  logic                clk,
    input  logic                rset,
    input  logic                plot_valid,
    output logic                plot_ready,
    input  logic [X_W-1:0]      px,
    input  logic [Y_W-1:0]      py,
    input  logic [COLOUR_W-1:0] pc,
    input  logic                clear,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [COLOUR_W-1:0] mem_data,
    output logic                mem_we,
    input  logic                mem_ack,
    output logic                busy,
    output logic [7:0]          dropped
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t             state;
    state_t             state_nxt;
    logic               clear_pending;
    logic [ADDR_W-1:0]  clear_cnt;

    logic               transfer;
    logic               in_range;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    pixel_t             fifo_head;
    pixel_t             new_pixel;
    logic               clear_done;

    assign in_range   = (px < X_W'(SCREEN_W)) && (py < Y_W'(SCREEN_H));
    assign transfer   = plot_valid && plot_ready;
    assign fifo_push  = transfer && in_range;
    assign fifo_pop   = (state == WRITE) && mem_ack;
    assign clear_done = (state == CLEAR) && mem_ack && (clear_cnt == LAST_ADDR);

    assign new_pixel.addr   = pixel_addr(px, py);
    assign new_pixel.colour = pc;

    // Readiness looks only at registered fullness, so a same-cycle pop never
    // opens a slot; held low while reset is asserted.
    assign plot_ready = !rset && !fifo_full && !clear_pending && (state != CLEAR);
    assign busy       = !fifo_empty || clear_pending || (state != IDLE);

    plot_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rset    (rset),
        .push    (fifo_push),
        .wr_data (new_pixel),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rset) begin
        if (rset) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic and framebuffer port drive.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        case (state)
            IDLE: begin
                if (clear_pending && fifo_empty) state_nxt = CLEAR;
                else if (!fifo_empty)            state_nxt = WRITE;
            end
            WRITE: begin
                mem_we   = 1'b1;
                mem_addr = fifo_head.addr;
                mem_data = fifo_head.colour;
                if (mem_ack) begin
                    if ((fifo_count > CNT_W'(1)) && !clear_pending) state_nxt = WRITE;
                    else                                            state_nxt = IDLE;
                end
            end
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = clear_cnt;
                mem_data = CLEAR_COLOUR;
                if (clear_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Clear request latch: set by any clear pulse outside CLEAR, dropped when
    // the sweep writes its last word.
    always_ff @(posedge clk or posedge rset) begin
        if (rset)                             clear_pending <= 1'b0;
        else if (clear_done)                  clear_pending <= 1'b0;
        else if (clear && (state != CLEAR))   clear_pending <= 1'b1;
    end

    // Clear sweep address: advances per acknowledged word, back to 0 at the end.
    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            clear_cnt <= '0;
        end else if ((state == CLEAR) && mem_ack) begin
            if (clear_cnt == LAST_ADDR) clear_cnt <= '0;
            else                        clear_cnt <= clear_cnt + ADDR_W'(1);
        end
    end

    // Saturating count of accepted but out-of-range pixels.
    always_ff @(posedge clk or posedge rset) begin
        if (rset)                                           dropped <= '0;
        else if (transfer && !in_range && (dropped != 8'hFF)) dropped <= dropped + 8'd1;
    end

endmodule
